mips_multi_control: RTL and testbench
=====================================

MIPS_MULTI_CONTROL -- requirements
Module: mips_multi_control

Interface
REQ-001 Parameter: ILLEGAL_TRAP, default 1, meaning 1 = unknown opcode/funct enters ERROR and halts, 0 = unknown opcode/funct returns to FETCH as a no-op.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  6  instruction bits [31:26], valid from DECODE onward.
REQ-005 funct  input  6  instruction bits [5:0].
REQ-006 zero  input  1  high when the ALU result equals 0.
REQ-007 mem_ready  input  1  memory handshake; the current access completes in any cycle it is high.
REQ-008 iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a  output  1 each  standard multicycle datapath controls.
REQ-009 alu_src_b  output  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-010 alu_ctrl  output  4  ALU select: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
REQ-011 pc_src  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-012 pc_en  output  1  PC write enable.
REQ-013 state_o  output  4  current state encoding, for debug.

Function
REQ-014 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, ERROR=15; encodings 12-14 are unused and return to FETCH on the next cycle.
REQ-015 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=0010, pc_src=00.
- ir_write and pc_en are high only in a cycle where mem_ready=1; FETCH is held while mem_ready=0.
REQ-016 DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=0010. Next state by opcode:
- 100011 or 101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP.
- Any other opcode -> ERROR or FETCH, per ILLEGAL_TRAP.
REQ-017 Opcode 000000 with an unknown funct is illegal and is resolved in DECODE, exactly as an unknown opcode.
REQ-018 MEMADR: alu_src_a=1, alu_src_b=10, alu_ctrl=0010; next state MEMRD for opcode 100011, MEMWR for opcode 101011.
REQ-019 MEMRD: iord=1, mem_read=1; held until mem_ready=1, then -> MEMWB.
REQ-020 MEMWR: iord=1, mem_write=1; held until mem_ready=1, then -> FETCH.
REQ-021 MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1; -> FETCH.
REQ-022 EXECUTE: alu_src_a=1, alu_src_b=00, alu_ctrl from funct (see below); -> ALUWB.
- funct mapping: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111, 100111->1100.
REQ-023 ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1; -> FETCH.
REQ-024 BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl=0110, pc_src=01, pc_en=zero (combinational); -> FETCH.
REQ-025 ADDIEX: alu_src_a=1, alu_src_b=10, alu_ctrl=0010; -> ADDIWB.
REQ-026 ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1; -> FETCH.
REQ-027 JUMP: pc_src=10, pc_en=1; -> FETCH.
REQ-028 ERROR: all enables low, absorbing; left only by reset.
REQ-029 All outputs are Moore-decoded from state, except the mem_ready-qualified ir_write/pc_en (FETCH) and zero-qualified pc_en (BRANCH); every output not listed for a state is 0.
REQ-030 Instruction latency with mem_ready tied high: lw 5 cycles; sw, R-type, addi 4; beq, j 3.

Reset
REQ-031 reset=1 at a clock edge forces FETCH on that edge, including mid-instruction or mid-handshake; no partial write is completed.
REQ-032 While reset=1 all write enables (mem_write, reg_write, ir_write, pc_en) are 0; state_o=0 on the first cycle after reset.

Configuration
REQ-033 Macro MIPS_MULTI_ADDI_EN, defined: opcode 001000 and states ADDIEX/ADDIWB are implemented as above.
REQ-034 MIPS_MULTI_ADDI_EN undefined: ADDIEX/ADDIWB are absent and opcode 001000 is illegal per ILLEGAL_TRAP.

Structure
REQ-035 Package mips_multi_pkg holds the state encodings, opcode constants, funct constants and the ALU select constants of REQ-010.
REQ-036 Sub-module mips_alu_decoder is combinational, maps funct to alu_ctrl plus a funct_valid flag, and is instantiated once.

Verification
REQ-037 reset pulse mid-MEMRD -> state_o=0 the next cycle, reg_write never asserted.
REQ-038 lw (0x8C...) with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with reg_write=1, mem_to_reg=1.
REQ-039 R-type funct=100010 -> EXECUTE alu_ctrl=0110, then ALUWB reg_dst=1; funct=100111 -> alu_ctrl=1100.
REQ-040 beq with zero=1 -> pc_en=1, pc_src=01 in BRANCH; with zero=0 -> pc_en=0.
REQ-041 opcode 111111: ILLEGAL_TRAP=1 -> ERROR persists for 10 cycles until reset; ILLEGAL_TRAP=0 -> FETCH after DECODE.
REQ-042 addi with MIPS_MULTI_ADDI_EN -> states 0,1,9,10,0; without the macro -> illegal handling per REQ-041.

Source files
------------

// File: rtl/mips_multi_pkg.sv
// mips_multi_pkg: shared constants for the multicycle MIPS controller.
// Holds state encodings, opcode/funct codes, ALU selects and the datapath
// control bundle used inside the controller.
package mips_multi_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALU_W   = 4;

  // FSM state encodings (12-14 unused)
  localparam logic [3:0] ST_FETCH   = 4'd0;
  localparam logic [3:0] ST_DECODE  = 4'd1;
  localparam logic [3:0] ST_MEMADR  = 4'd2;
  localparam logic [3:0] ST_MEMRD   = 4'd3;
  localparam logic [3:0] ST_MEMWB   = 4'd4;
  localparam logic [3:0] ST_MEMWR   = 4'd5;
  localparam logic [3:0] ST_EXECUTE = 4'd6;
  localparam logic [3:0] ST_ALUWB   = 4'd7;
  localparam logic [3:0] ST_BRANCH  = 4'd8;
  localparam logic [3:0] ST_ADDIEX  = 4'd9;
  localparam logic [3:0] ST_ADDIWB  = 4'd10;
  localparam logic [3:0] ST_JUMP    = 4'd11;
  localparam logic [3:0] ST_ERROR   = 4'd15;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  // ALU selects
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // ALU B-operand and PC source selects
  localparam logic [1:0] ALUB_B     = 2'b00;
  localparam logic [1:0] ALUB_FOUR  = 2'b01;
  localparam logic [1:0] ALUB_IMM   = 2'b10;
  localparam logic [1:0] ALUB_IMMSH = 2'b11;
  localparam logic [1:0] PC_ALU     = 2'b00;
  localparam logic [1:0] PC_ALUOUT  = 2'b01;
  localparam logic [1:0] PC_JUMP    = 2'b10;

  // Datapath control bundle driven by the controller
  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctrl;
    logic [1:0] pc_src;
    logic       pc_en;
  } ctrl_t;

endpackage

// File: rtl/mips_multi_if.sv
// mips_multi_if: controller <-> datapath signal bundle.
//   master (controller): in  opcode, funct, zero, mem_ready
//                        out datapath controls, state_o
//   slave  (datapath):   the reverse
interface mips_multi_if;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_ctrl;
  logic [1:0] pc_src;
  logic       pc_en;
  logic [3:0] state_o;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, pc_en, state_o
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, pc_en, state_o
  );

endinterface

// File: rtl/mips_alu_decoder.sv
// mips_alu_decoder: combinational R-type funct -> ALU select.
//   funct       in  6  instruction bits [5:0]
//   alu_ctrl    out 4  ALU select (ADD when funct is unknown)
//   funct_valid out 1  funct is one of the supported R-type operations
module mips_alu_decoder
  import mips_multi_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       funct_valid
);

  always_comb begin
    alu_ctrl    = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      FN_NOR:  alu_ctrl = ALU_NOR;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multi_control.sv
// mips_multi_control: multicycle MIPS main controller FSM.
//   clk    in  single clock, rising edge
//   reset  in  synchronous active-high reset (state -> FETCH)
//   bus    mips_multi_if.master: opcode/funct/zero/mem_ready in,
//          datapath controls and state_o (debug) out
// Parameter ILLEGAL_TRAP: 1 = unknown opcode/funct halts in ERROR,
//                         0 = unknown opcode/funct falls back to FETCH.
// Macro MIPS_MULTI_ADDI_EN: when defined, addi (ADDIEX/ADDIWB) is supported;
// otherwise opcode 001000 is treated as illegal.
module mips_multi_control
  import mips_multi_pkg::*;
#(
  parameter int unsigned ILLEGAL_TRAP = 1
) (
  input  logic         clk,
  input  logic         reset,
  mips_multi_if.master bus
);

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic [3:0] illegal_nxt;
  logic [3:0] fn_alu;
  logic       fn_valid;
  ctrl_t      ctl;

  mips_alu_decoder u_alu_dec (
    .funct       (bus.funct),
    .alu_ctrl    (fn_alu),
    .funct_valid (fn_valid)
  );

  assign illegal_nxt = (ILLEGAL_TRAP != 0) ? ST_ERROR : ST_FETCH;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_FETCH;
    else       state <= state_nxt;
  end

  // Next-state and Moore control decode (mem_ready/zero qualify pc_en/ir_write)
  always_comb begin
    state_nxt = state;
    ctl       = '0;
    case (state)
      ST_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = ALUB_FOUR;
        ctl.alu_ctrl  = ALU_ADD;
        ctl.pc_src    = PC_ALU;
        if (bus.mem_ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_en    = 1'b1;
          state_nxt    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        ctl.alu_src_b = ALUB_IMMSH;
        ctl.alu_ctrl  = ALU_ADD;
        case (bus.opcode)
          OP_LW, OP_SW: state_nxt = ST_MEMADR;
          OP_RTYPE:     state_nxt = fn_valid ? ST_EXECUTE : illegal_nxt;
          OP_BEQ:       state_nxt = ST_BRANCH;
`ifdef MIPS_MULTI_ADDI_EN
          OP_ADDI:      state_nxt = ST_ADDIEX;
`endif
          OP_J:         state_nxt = ST_JUMP;
          default:      state_nxt = illegal_nxt;
        endcase
      end
      ST_MEMADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = ALUB_IMM;
        ctl.alu_ctrl  = ALU_ADD;
        // opcode is stable here; anything other than lw/sw cannot reach this state
        if (bus.opcode == OP_LW)      state_nxt = ST_MEMRD;
        else if (bus.opcode == OP_SW) state_nxt = ST_MEMWR;
        else                          state_nxt = ST_FETCH;
      end
      ST_MEMRD: begin
        ctl.iord     = 1'b1;
        ctl.mem_read = 1'b1;
        if (bus.mem_ready) state_nxt = ST_MEMWB;
      end
      ST_MEMWB: begin
        ctl.mem_to_reg = 1'b1;
        ctl.reg_write  = 1'b1;
        state_nxt      = ST_FETCH;
      end
      ST_MEMWR: begin
        ctl.iord      = 1'b1;
        ctl.mem_write = 1'b1;
        if (bus.mem_ready) state_nxt = ST_FETCH;
      end
      ST_EXECUTE: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = ALUB_B;
        ctl.alu_ctrl  = fn_alu;
        state_nxt     = ST_ALUWB;
      end
      ST_ALUWB: begin
        ctl.reg_dst   = 1'b1;
        ctl.reg_write = 1'b1;
        state_nxt     = ST_FETCH;
      end
      ST_BRANCH: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = ALUB_B;
        ctl.alu_ctrl  = ALU_SUB;
        ctl.pc_src    = PC_ALUOUT;
        ctl.pc_en     = bus.zero;
        state_nxt     = ST_FETCH;
      end
`ifdef MIPS_MULTI_ADDI_EN
      ST_ADDIEX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = ALUB_IMM;
        ctl.alu_ctrl  = ALU_ADD;
        state_nxt     = ST_ADDIWB;
      end
      ST_ADDIWB: begin
        ctl.reg_write = 1'b1;
        state_nxt     = ST_FETCH;
      end
`endif
      ST_JUMP: begin
        ctl.pc_src = PC_JUMP;
        ctl.pc_en  = 1'b1;
        state_nxt  = ST_FETCH;
      end
      ST_ERROR: state_nxt = ST_ERROR;
      default:  state_nxt = ST_FETCH;
    endcase
  end

  // Write enables are suppressed while reset is held so nothing commits mid-reset
  assign bus.iord       = ctl.iord;
  assign bus.mem_read   = ctl.mem_read;
  assign bus.mem_write  = ctl.mem_write & ~reset;
  assign bus.ir_write   = ctl.ir_write & ~reset;
  assign bus.reg_dst    = ctl.reg_dst;
  assign bus.mem_to_reg = ctl.mem_to_reg;
  assign bus.reg_write  = ctl.reg_write & ~reset;
  assign bus.alu_src_a  = ctl.alu_src_a;
  assign bus.alu_src_b  = ctl.alu_src_b;
  assign bus.alu_ctrl   = ctl.alu_ctrl;
  assign bus.pc_src     = ctl.pc_src;
  assign bus.pc_en      = ctl.pc_en & ~reset;
  assign bus.state_o    = state;

endmodule

// File: tb/tb_mips_multi_control.sv
// tb_mips_multi_control: directed bench for mips_multi_control.
// Two instances run in lockstep: dut_t (ILLEGAL_TRAP=1) and dut_n (ILLEGAL_TRAP=0).
// Each step pushes the expected state and control vector for both; a
// negedge checker pops and compares.
module tb_mips_multi_control;

  localparam logic [3:0] S_F   = 4'd0;
  localparam logic [3:0] S_D   = 4'd1;
  localparam logic [3:0] S_MA  = 4'd2;
  localparam logic [3:0] S_MR  = 4'd3;
  localparam logic [3:0] S_MB  = 4'd4;
  localparam logic [3:0] S_MW  = 4'd5;
  localparam logic [3:0] S_EX  = 4'd6;
  localparam logic [3:0] S_AW  = 4'd7;
  localparam logic [3:0] S_BR  = 4'd8;
  localparam logic [3:0] S_AE  = 4'd9;
  localparam logic [3:0] S_AB  = 4'd10;
  localparam logic [3:0] S_JP  = 4'd11;
  localparam logic [3:0] S_ER  = 4'd15;

  localparam logic [5:0] LW   = 6'h23;
  localparam logic [5:0] SW   = 6'h2b;
  localparam logic [5:0] RT   = 6'h00;
  localparam logic [5:0] BEQ  = 6'h04;
  localparam logic [5:0] ADDI = 6'h08;
  localparam logic [5:0] JMP  = 6'h02;
  localparam logic [5:0] BAD  = 6'h3f;

  typedef struct packed {
    logic [3:0]  st_t;
    logic [16:0] c_t;
    logic [3:0]  st_n;
    logic [16:0] c_n;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];

  always #5 clk = ~clk;

  mips_multi_if bus_t ();
  mips_multi_if bus_n ();

  assign bus_t.opcode    = opcode;
  assign bus_t.funct     = funct;
  assign bus_t.zero      = zero;
  assign bus_t.mem_ready = mem_ready;
  assign bus_n.opcode    = opcode;
  assign bus_n.funct     = funct;
  assign bus_n.zero      = zero;
  assign bus_n.mem_ready = mem_ready;

  mips_multi_control #(.ILLEGAL_TRAP(1)) dut_t (.clk(clk), .reset(reset), .bus(bus_t));
  mips_multi_control #(.ILLEGAL_TRAP(0)) dut_n (.clk(clk), .reset(reset), .bus(bus_n));

  // {iord,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a,
  //  alu_src_b[1:0],alu_ctrl[3:0],pc_src[1:0],pc_en}
  logic [16:0] obs_t;
  logic [16:0] obs_n;
  assign obs_t = {bus_t.iord, bus_t.mem_read, bus_t.mem_write, bus_t.ir_write,
                  bus_t.reg_dst, bus_t.mem_to_reg, bus_t.reg_write, bus_t.alu_src_a,
                  bus_t.alu_src_b, bus_t.alu_ctrl, bus_t.pc_src, bus_t.pc_en};
  assign obs_n = {bus_n.iord, bus_n.mem_read, bus_n.mem_write, bus_n.ir_write,
                  bus_n.reg_dst, bus_n.mem_to_reg, bus_n.reg_write, bus_n.alu_src_a,
                  bus_n.alu_src_b, bus_n.alu_ctrl, bus_n.pc_src, bus_n.pc_en};

  // Reference control table
  function automatic logic [16:0] golden(input logic [3:0] st, input logic r,
                                         input logic mr, input logic z,
                                         input logic [5:0] fn);
    logic       iord, mrd, mwr, irw, rdst, m2r, rw, asa, pce;
    logic [1:0] asb, pcs;
    logic [3:0] alu;
    iord = 0; mrd = 0; mwr = 0; irw = 0; rdst = 0; m2r = 0; rw = 0; asa = 0;
    pce = 0; asb = 2'b00; pcs = 2'b00; alu = 4'b0000;
    case (st)
      4'd0:  begin mrd = 1; asb = 2'b01; alu = 4'b0010; irw = mr; pce = mr; end
      4'd1:  begin asb = 2'b11; alu = 4'b0010; end
      4'd2:  begin asa = 1; asb = 2'b10; alu = 4'b0010; end
      4'd3:  begin iord = 1; mrd = 1; end
      4'd4:  begin m2r = 1; rw = 1; end
      4'd5:  begin iord = 1; mwr = 1; end
      4'd6:  begin
        asa = 1;
        case (fn)
          6'h20:   alu = 4'b0010;
          6'h22:   alu = 4'b0110;
          6'h24:   alu = 4'b0000;
          6'h25:   alu = 4'b0001;
          6'h2a:   alu = 4'b0111;
          6'h27:   alu = 4'b1100;
          default: alu = 4'b0010;
        endcase
      end
      4'd7:  begin rdst = 1; rw = 1; end
      4'd8:  begin asa = 1; alu = 4'b0110; pcs = 2'b01; pce = z; end
      4'd9:  begin asa = 1; asb = 2'b10; alu = 4'b0010; end
      4'd10: begin rw = 1; end
      4'd11: begin pcs = 2'b10; pce = 1; end
      default: ;
    endcase
    if (r) begin
      mwr = 0; rw = 0; irw = 0; pce = 0;
    end
    return {iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, alu, pcs, pce};
  endfunction

  // Drive one cycle of inputs and queue what both instances must show in it
  task automatic step(input logic [3:0] st_t, input logic [3:0] st_n, input logic r,
                      input logic mr, input logic z, input logic [5:0] op,
                      input logic [5:0] fn);
    exp_t e;
    reset = r; mem_ready = mr; zero = z; opcode = op; funct = fn;
    e.st_t = st_t;
    e.c_t  = golden(st_t, r, mr, z, fn);
    e.st_n = st_n;
    e.c_n  = golden(st_n, r, mr, z, fn);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic s(input logic [3:0] st, input logic r, input logic mr,
                   input logic z, input logic [5:0] op, input logic [5:0] fn);
    step(st, st, r, mr, z, op, fn);
  endtask

  // Illegal instruction: trap instance sits in ERROR, the other keeps refetching
  task automatic illegal_seq(input logic [5:0] op, input logic [5:0] fn);
    s(S_F, 0, 1, 0, op, fn);
    s(S_D, 0, 1, 0, op, fn);
    for (int k = 0; k < 10; k++)
      step(S_ER, (k % 2 == 0) ? S_F : S_D, 0, 1, 0, op, fn);
    step(S_ER, S_F, 1, 1, 0, op, fn);
  endtask

  // Scoreboard checker, sampled mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (bus_t.state_o === e.st_t) else begin
        errors++;
        $error("FAIL state_trap got %0d exp %0d", bus_t.state_o, e.st_t);
      end
      checks++;
      assert (obs_t === e.c_t) else begin
        errors++;
        $error("FAIL ctrl_trap st=%0d got %b exp %b", e.st_t, obs_t, e.c_t);
      end
      checks++;
      assert (bus_n.state_o === e.st_n) else begin
        errors++;
        $error("FAIL state_nop got %0d exp %0d", bus_n.state_o, e.st_n);
      end
      checks++;
      assert (obs_n === e.c_n) else begin
        errors++;
        $error("FAIL ctrl_nop st=%0d got %b exp %b", e.st_n, obs_n, e.c_n);
      end
    end
  end

  logic [5:0] fn_list [6];

  initial begin
    fn_list[0] = 6'h22; fn_list[1] = 6'h27; fn_list[2] = 6'h20;
    fn_list[3] = 6'h24; fn_list[4] = 6'h25; fn_list[5] = 6'h2a;
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = 6'h00; funct = 6'h00;
    @(posedge clk);
    #1;

    // Reset held: FETCH with writes suppressed
    s(S_F, 1, 1, 0, LW, 0);

    // lw with fetch stall and three-cycle MEMRD stall
    s(S_F, 0, 0, 0, LW, 0);
    s(S_F, 0, 1, 0, LW, 0);
    s(S_D, 0, 1, 0, LW, 0);
    s(S_MA, 0, 1, 0, LW, 0);
    repeat (3) s(S_MR, 0, 0, 0, LW, 0);
    s(S_MR, 0, 1, 0, LW, 0);
    s(S_MB, 0, 1, 0, LW, 0);

    // sw with one stall cycle
    s(S_F, 0, 1, 0, SW, 0);
    s(S_D, 0, 1, 0, SW, 0);
    s(S_MA, 0, 1, 0, SW, 0);
    s(S_MW, 0, 0, 0, SW, 0);
    s(S_MW, 0, 1, 0, SW, 0);

    // R-type, every supported funct
    for (int i = 0; i < 6; i++) begin
      s(S_F, 0, 1, 0, RT, fn_list[i]);
      s(S_D, 0, 1, 0, RT, fn_list[i]);
      s(S_EX, 0, 1, 0, RT, fn_list[i]);
      s(S_AW, 0, 1, 0, RT, fn_list[i]);
    end

    // beq taken / not taken
    s(S_F, 0, 1, 0, BEQ, 0);
    s(S_D, 0, 1, 0, BEQ, 0);
    s(S_BR, 0, 1, 1, BEQ, 0);
    s(S_F, 0, 1, 0, BEQ, 0);
    s(S_D, 0, 1, 0, BEQ, 0);
    s(S_BR, 0, 1, 0, BEQ, 0);

    // j
    s(S_F, 0, 1, 0, JMP, 0);
    s(S_D, 0, 1, 0, JMP, 0);
    s(S_JP, 0, 1, 0, JMP, 0);

    // addi
`ifdef MIPS_MULTI_ADDI_EN
    s(S_F, 0, 1, 0, ADDI, 0);
    s(S_D, 0, 1, 0, ADDI, 0);
    s(S_AE, 0, 1, 0, ADDI, 0);
    s(S_AB, 0, 1, 0, ADDI, 0);
`else
    illegal_seq(ADDI, 6'h00);
`endif

    // Unknown opcode, then R-type with unknown funct
    illegal_seq(BAD, 6'h00);
    illegal_seq(RT, 6'h3f);

    // Reset pulse mid-MEMRD: no writeback follows
    s(S_F, 0, 1, 0, LW, 0);
    s(S_D, 0, 1, 0, LW, 0);
    s(S_MA, 0, 1, 0, LW, 0);
    s(S_MR, 0, 0, 0, LW, 0);
    s(S_MR, 1, 0, 0, LW, 0);
    s(S_F, 0, 0, 0, LW, 0);

    // Reset mid-MEMWR handshake: mem_write suppressed
    s(S_F, 0, 1, 0, SW, 0);
    s(S_D, 0, 1, 0, SW, 0);
    s(S_MA, 0, 1, 0, SW, 0);
    s(S_MW, 1, 1, 0, SW, 0);
    s(S_F, 0, 1, 0, SW, 0);

    // Drain scoreboard within a bounded number of cycles
    for (int w = 0; w < 4 && sb.size() > 0; w++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d exp 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard timeout guard
  initial begin
    #100000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

endmodule
